// File: rtl/fifo_output_control.sv
// Read-side control for the 16-entry FIFO: occupancy tracking, read pointer/strobe, underflow and data-valid.
// Optional almost_empty output is enabled by defining FIFO_ALMOST_EMPTY_EN.
module fifo_output_control #(
  parameter int DEPTH     = 16,
  parameter int PTR_W     = 5,
  parameter int AE_THRESH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             read_en,
  input  logic             wr_commit,
  output logic             read_en_o,
  output logic [PTR_W-1:0] ptr,
  output logic             valid,
  output logic             empty,
  output logic             underflow
`ifdef FIFO_ALMOST_EMPTY_EN
  ,
  output logic             almost_empty
`endif
);

  typedef enum logic {S_EMPTY, S_NONEMPTY} state_t;

  localparam logic [PTR_W-1:0] FULL     = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] IDX_MASK = PTR_W'(DEPTH - 1);

  state_t           state;
  state_t           state_next;
  logic [PTR_W-1:0] count;
  logic [PTR_W-1:0] count_next;
  logic [PTR_W-1:0] rd_idx;
  logic             accept;
  logic             inc;

  // A read is judged on the registered count, so a same-cycle write never bypasses an empty FIFO.
  assign accept = read_en && (count != '0);
  assign inc    = wr_commit && (count != FULL);

  always_comb begin
    count_next = count;
    case ({inc, accept})
      2'b10:   count_next = count + PTR_W'(1);
      2'b01:   count_next = count - PTR_W'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_EMPTY: begin
        if (wr_commit) state_next = S_NONEMPTY;
      end
      S_NONEMPTY: begin
        if ((count == PTR_W'(1)) && accept && !wr_commit) state_next = S_EMPTY;
      end
      default: state_next = S_EMPTY;
    endcase
  end

  always_comb begin
    empty = (state == S_EMPTY);
  end

  // Pointer only advances on accepted reads; it holds its last address otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      rd_idx    <= '0;
      ptr       <= '0;
      read_en_o <= 1'b0;
      valid     <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= count_next;
      valid     <= read_en_o;
      read_en_o <= accept;
      if (accept) begin
        ptr       <= rd_idx;
        rd_idx    <= (rd_idx + PTR_W'(1)) & IDX_MASK;
        underflow <= 1'b0;
      end else if (read_en) begin
        underflow <= 1'b1;
      end
    end
  end

`ifdef FIFO_ALMOST_EMPTY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      almost_empty <= 1'b1;
    end else begin
      almost_empty <= (count_next <= PTR_W'(AE_THRESH));
    end
  end
`endif

endmodule

// File: tb/tb_fifo_output_control.sv
// Self-checking bench for fifo_output_control: directed scenarios then random traffic,
// compared each cycle against an occupancy/index reference model.
module tb_fifo_output_control;

  localparam int DEPTH     = 16;
  localparam int PTR_W     = 5;
  localparam int AE_THRESH = 2;

  logic             clk;
  logic             reset;
  logic             read_en;
  logic             wr_commit;
  logic             read_en_o;
  logic [PTR_W-1:0] ptr;
  logic             valid;
  logic             empty;
  logic             underflow;
`ifdef FIFO_ALMOST_EMPTY_EN
  logic             almost_empty;
`endif

  int total;
  int bad;

  // Reference model: plain occupancy number, next read index, and last-cycle strobes.
  int m_count;
  int m_idx;
  int m_ptr;
  bit m_reo;
  bit m_valid;
  bit m_uf;

  fifo_output_control #(
    .DEPTH(DEPTH), .PTR_W(PTR_W), .AE_THRESH(AE_THRESH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .read_en(read_en),
    .wr_commit(wr_commit),
    .read_en_o(read_en_o),
    .ptr(ptr),
    .valid(valid),
    .empty(empty),
    .underflow(underflow)
`ifdef FIFO_ALMOST_EMPTY_EN
    ,
    .almost_empty(almost_empty)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic modelStep(input bit re, input bit wc, input bit rst);
    bit acc;
    if (rst) begin
      m_count = 0; m_idx = 0; m_ptr = 0;
      m_reo = 0; m_valid = 0; m_uf = 0;
    end else begin
      acc     = re && (m_count > 0);
      m_valid = m_reo;
      m_reo   = acc;
      if (acc) begin
        m_ptr = m_idx;
        m_idx = (m_idx + 1) % DEPTH;
        m_uf  = 0;
      end else if (re) begin
        m_uf = 1;
      end
      if (wc && m_count < DEPTH) m_count = m_count + 1;
      if (acc) m_count = m_count - 1;
    end
  endtask

  task automatic applyStimulus(input bit re, input bit wc, input bit rst);
    @(negedge clk);
    read_en   = re;
    wr_commit = wc;
    reset     = rst;
    @(posedge clk);
    modelStep(re, wc, rst);
    #1;
    checkOutput("read_en_o", 32'(read_en_o), 32'(m_reo));
    checkOutput("ptr",       32'(ptr),       32'(m_ptr));
    checkOutput("valid",     32'(valid),     32'(m_valid));
    checkOutput("empty",     32'(empty),     32'(m_count == 0));
    checkOutput("underflow", 32'(underflow), 32'(m_uf));
`ifdef FIFO_ALMOST_EMPTY_EN
    checkOutput("almost_empty", 32'(almost_empty), 32'(m_count <= AE_THRESH));
`endif
  endtask

  initial begin
    total = 0;
    bad   = 0;
    read_en = 0; wr_commit = 0; reset = 1;
    m_count = 0; m_idx = 0; m_ptr = 0; m_reo = 0; m_valid = 0; m_uf = 0;

    // Reset, then read of an empty FIFO
    applyStimulus(0, 0, 1);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 1, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);

    // Fill to DEPTH, drain back-to-back, then one underflowing read
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 1, 0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);

    // Pointer wrap across two batches of ten
    applyStimulus(0, 0, 1);
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0);
      for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0);
    end
    applyStimulus(0, 0, 0);

    // Simultaneous write and read at count 3 and at count 0
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0);
    applyStimulus(1, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0);
    applyStimulus(1, 1, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);

    // Saturation: one write too many is ignored
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus(0, 1, 0);
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1, 0, 0);

    // Reset lands while a read's valid is in flight
    applyStimulus(0, 1, 0);
    applyStimulus(0, 1, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 0);

    // Walk occupancy across the almost-empty threshold
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0);

    // Random traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      applyStimulus(bit'($urandom_range(0, 99) < 45),
                    bit'($urandom_range(0, 99) < 50),
                    bit'($urandom_range(0, 99) < 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
